// File: rtl/ar_addr_stage_if.sv
// AXI4-Lite read-address / memory-read / R-stage hand-off bundle for ar_addr_stage.
// The slave modport is the address stage, the master modport is everything around it.
interface ar_addr_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  ARVALID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARREADY;
  logic                  MREN;
  logic [ADDR_WIDTH-1:0] MADDR;
  logic                  MEM_ACK;
  logic [DATA_WIDTH-1:0] MEM_RDATA;
  logic [1:0]            MEM_RESP;
  logic                  MREADY;
  logic [DATA_WIDTH-1:0] MDATA;
  logic [1:0]            MRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  ARVALID, ARADDR, ARPROT, MEM_ACK, MEM_RDATA, MEM_RESP, RVALID, RREADY,
    output ARREADY, MREN, MADDR, MREADY, MDATA, MRESP
  );

  modport master (
    output ARVALID, ARADDR, ARPROT, MEM_ACK, MEM_RDATA, MEM_RESP, RVALID, RREADY,
    input  ARREADY, MREN, MADDR, MREADY, MDATA, MRESP
  );
endinterface

// File: rtl/ar_addr_stage.sv
// AXI4-Lite read-address stage: accepts one AR at a time, checks it, reads a word
// from backing memory (with timeout) and holds the result until the R stage drains it.
module ar_addr_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            resetn,
  ar_addr_stage_if.slave  bus
);

  localparam int        CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, MEMRD, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [1:0]            mresp_q, mresp_d;
  logic                  arready_q, mren_q, mready_q;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;

  // Range check on the full word index so high address bits can never alias low words.
  assign widx     = bus.ARADDR >> 2;
  assign in_range = 64'(widx) < 64'(MEM_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mresp_d = mresp_q;
    case (state_q)
      IDLE: begin
        if (bus.ARVALID && arready_q) begin
          maddr_d = widx;
          if (bus.ARADDR[1:0] != 2'b00) begin
            state_d = HOLD;
            mresp_d = RESP_SLVERR;
            mdata_d = '0;
          end else if (!in_range) begin
            state_d = HOLD;
            mresp_d = RESP_DECERR;
            mdata_d = '0;
          end else begin
            state_d = MEMRD;
            cnt_d   = '0;
          end
        end
      end
      MEMRD: begin
        // Ack is tested first so an ack on the last allowed cycle still wins.
        if (bus.MEM_ACK) begin
          state_d = HOLD;
          mdata_d = bus.MEM_RDATA;
          mresp_d = bus.MEM_RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          mdata_d = '0;
          mresp_d = RESP_SLVERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.RVALID && bus.RREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state so they stay low in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      maddr_q   <= '0;
      mdata_q   <= '0;
      mresp_q   <= '0;
      arready_q <= 1'b0;
      mren_q    <= 1'b0;
      mready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      maddr_q   <= maddr_d;
      mdata_q   <= mdata_d;
      mresp_q   <= mresp_d;
      arready_q <= (state_d == IDLE);
      mren_q    <= (state_d == MEMRD);
      mready_q  <= (state_d == HOLD);
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.MREN    = mren_q;
  assign bus.MADDR   = maddr_q;
  assign bus.MREADY  = mready_q;
  assign bus.MDATA   = mdata_q;
  assign bus.MRESP   = mresp_q;

  logic unused_arprot;
  assign unused_arprot = ^bus.ARPROT;

endmodule

// File: tb/tb_ar_addr_stage.sv
// Randomized bench for ar_addr_stage: the bench plays AXI master, memory and R stage,
// and compares each transaction against a per-access outcome model.
module tb_ar_addr_stage;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 256;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ar_addr_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ar_addr_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // observations from the last transaction
  int nmren, lat;
  logic [AW-1:0] maddr_seen;
  logic [DW-1:0] mdata_seen;
  logic [1:0] mresp_seen;
  logic maddr_stable, hold_stable, ar_blocked, arready_pre, mready_after, arready_after;

  // expected outcome of one access
  int emren, elat;
  logic [DW-1:0] edata;
  logic [1:0] eresp;

  function automatic void model(input logic [AW-1:0] a, input int waits,
                                input logic [DW-1:0] rd, input logic [1:0] rs);
    longint unsigned word = longint'(a) / 4;
    if (a % 4 != 0) begin
      emren = 0; elat = 1; edata = '0; eresp = 2'b10;
    end else if (word >= MW) begin
      emren = 0; elat = 1; edata = '0; eresp = 2'b11;
    end else if (waits < TO) begin
      emren = waits + 1; elat = waits + 2; edata = rd; eresp = rs;
    end else begin
      emren = TO; elat = TO + 1; edata = '0; eresp = 2'b10;
    end
  endfunction

  // One full transaction: AR handshake, memory that acks after 'waits' MREN cycles,
  // R stage that stalls 'hold' cycles while a second AR waits, then releases.
  task automatic run_read(input logic [AW-1:0] a, input int waits, input logic [DW-1:0] rd,
                          input logic [1:0] rs, input int hold, input bit late);
    nmren = 0; lat = -1; maddr_seen = '0;
    maddr_stable = 1'b1; hold_stable = 1'b1; ar_blocked = 1'b1;
    arready_pre = bus.ARREADY;
    bus.ARVALID = 1'b1; bus.ARADDR = a; bus.ARPROT = 3'($urandom);
    bus.MEM_ACK = late;
    @(posedge clk); #1;
    bus.ARVALID = 1'b0; bus.ARADDR = $urandom;
    for (int t = 1; t <= TO + 8; t++) begin
      bus.MEM_ACK = 1'b0; bus.MEM_RDATA = $urandom; bus.MEM_RESP = 2'($urandom);
      if (bus.MREADY) begin lat = t; break; end
      if (bus.ARREADY) ar_blocked = 1'b0;
      if (bus.MREN) begin
        if (nmren == 0) maddr_seen = bus.MADDR;
        else if (bus.MADDR !== maddr_seen) maddr_stable = 1'b0;
        if (nmren == waits) begin
          bus.MEM_ACK = 1'b1; bus.MEM_RDATA = rd; bus.MEM_RESP = rs;
        end
        nmren++;
      end
      @(posedge clk); #1;
    end
    mdata_seen = bus.MDATA; mresp_seen = bus.MRESP;
    for (int h = 0; h < hold; h++) begin
      bus.RVALID = 1'($urandom); bus.RREADY = 1'b0;
      bus.ARVALID = 1'b1; bus.ARADDR = 32'($urandom_range(0, MW - 1)) << 2;
      bus.MEM_ACK = late; bus.MEM_RDATA = $urandom; bus.MEM_RESP = 2'($urandom);
      if (!bus.MREADY || bus.MDATA !== mdata_seen || bus.MRESP !== mresp_seen) hold_stable = 1'b0;
      if (bus.ARREADY) ar_blocked = 1'b0;
      @(posedge clk); #1;
    end
    if (!bus.MREADY || bus.MDATA !== mdata_seen || bus.MRESP !== mresp_seen) hold_stable = 1'b0;
    if (bus.ARREADY) ar_blocked = 1'b0;
    bus.ARVALID = 1'b0; bus.MEM_ACK = 1'b0; bus.RVALID = 1'b1; bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.RVALID = 1'b0; bus.RREADY = 1'b0;
    mready_after = bus.MREADY; arready_after = bus.ARREADY;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if ({bus.ARREADY, bus.MREN, bus.MREADY, bus.MRESP} !== 5'b0) begin miscompares++; $display("FAIL rst_flags got %b exp 00000", {bus.ARREADY, bus.MREN, bus.MREADY, bus.MRESP}); end
    vectors++; if (bus.MADDR !== '0) begin miscompares++; $display("FAIL rst_maddr got %h exp 0", bus.MADDR); end
    vectors++; if (bus.MDATA !== '0) begin miscompares++; $display("FAIL rst_mdata got %h exp 0", bus.MDATA); end
    @(negedge clk); resetn = 1'b1; #1;
    vectors++; if (bus.ARREADY !== 1'b0) begin miscompares++; $display("FAIL rst_arready_pre_edge got %b exp 0", bus.ARREADY); end
    @(posedge clk); #1;
    vectors++; if (bus.ARREADY !== 1'b1) begin miscompares++; $display("FAIL rst_arready_post_edge got %b exp 1", bus.ARREADY); end
  endtask

  task automatic test_zero_wait();
    run_read(32'h10, 0, 32'hDEADBEEF, 2'b00, 3, 1'b0);
    vectors++; if (arready_pre !== 1'b1) begin miscompares++; $display("FAIL zw_arready got %b exp 1", arready_pre); end
    vectors++; if (nmren !== 1) begin miscompares++; $display("FAIL zw_mren_cycles got %0d exp 1", nmren); end
    vectors++; if (maddr_seen !== 32'd4) begin miscompares++; $display("FAIL zw_maddr got %0d exp 4", maddr_seen); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL zw_latency got %0d exp 2", lat); end
    vectors++; if (mdata_seen !== 32'hDEADBEEF) begin miscompares++; $display("FAIL zw_mdata got %h exp deadbeef", mdata_seen); end
    vectors++; if (mresp_seen !== 2'b00) begin miscompares++; $display("FAIL zw_mresp got %b exp 00", mresp_seen); end
    vectors++; if ({hold_stable, ar_blocked} !== 2'b11) begin miscompares++; $display("FAIL zw_hold_blocked got %b exp 11", {hold_stable, ar_blocked}); end
    vectors++; if ({mready_after, arready_after} !== 2'b01) begin miscompares++; $display("FAIL zw_release got %b exp 01", {mready_after, arready_after}); end
  endtask

  task automatic test_misaligned();
    run_read(32'h0000_0402, 0, $urandom, 2'b00, 1, 1'b1);
    vectors++; if (nmren !== 0) begin miscompares++; $display("FAIL mis_mren got %0d exp 0", nmren); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mis_latency got %0d exp 1", lat); end
    vectors++; if (mresp_seen !== 2'b10) begin miscompares++; $display("FAIL mis_mresp got %b exp 10", mresp_seen); end
    vectors++; if (mdata_seen !== '0) begin miscompares++; $display("FAIL mis_mdata got %h exp 0", mdata_seen); end
  endtask

  task automatic test_range();
    logic [DW-1:0] rd;
    run_read(32'h400, 0, $urandom, 2'b00, 0, 1'b0);
    vectors++; if ({nmren, lat} !== {32'd0, 32'd1}) begin miscompares++; $display("FAIL rng_400_timing got mren=%0d lat=%0d exp 0/1", nmren, lat); end
    vectors++; if (mresp_seen !== 2'b11) begin miscompares++; $display("FAIL rng_400_mresp got %b exp 11", mresp_seen); end
    run_read(32'h0001_0000, 0, $urandom, 2'b00, 0, 1'b0);
    vectors++; if (mresp_seen !== 2'b11 || nmren !== 0) begin miscompares++; $display("FAIL rng_high_bits got mresp=%b mren=%0d exp 11/0", mresp_seen, nmren); end
    rd = $urandom;
    run_read(32'h3FC, 2, rd, 2'b01, 0, 1'b0);
    vectors++; if (maddr_seen !== 32'd255) begin miscompares++; $display("FAIL rng_3fc_maddr got %0d exp 255", maddr_seen); end
    vectors++; if (nmren !== 3 || lat !== 4) begin miscompares++; $display("FAIL rng_3fc_timing got mren=%0d lat=%0d exp 3/4", nmren, lat); end
    vectors++; if (mdata_seen !== rd || mresp_seen !== 2'b01) begin miscompares++; $display("FAIL rng_3fc_result got %h/%b exp %h/01", mdata_seen, mresp_seen, rd); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd;
    run_read(32'h20, NEVER, $urandom, 2'b00, 4, 1'b1);
    vectors++; if (nmren !== TO) begin miscompares++; $display("FAIL to_mren_cycles got %0d exp %0d", nmren, TO); end
    vectors++; if (lat !== TO + 1) begin miscompares++; $display("FAIL to_latency got %0d exp %0d", lat, TO + 1); end
    vectors++; if (mresp_seen !== 2'b10 || mdata_seen !== '0) begin miscompares++; $display("FAIL to_result got %h/%b exp 0/10", mdata_seen, mresp_seen); end
    vectors++; if (hold_stable !== 1'b1) begin miscompares++; $display("FAIL to_late_ack got stable=%b exp 1", hold_stable); end
    rd = $urandom;
    run_read(32'h24, TO - 1, rd, 2'b01, 0, 1'b0);
    vectors++; if (nmren !== TO || lat !== TO + 1) begin miscompares++; $display("FAIL to_edge_timing got mren=%0d lat=%0d exp %0d/%0d", nmren, lat, TO, TO + 1); end
    vectors++; if (mdata_seen !== rd || mresp_seen !== 2'b01) begin miscompares++; $display("FAIL to_edge_ack_wins got %h/%b exp %h/01", mdata_seen, mresp_seen, rd); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd;
    rd = $urandom;
    run_read(32'h44, 3, rd, 2'b10, 5, 1'b0);
    vectors++; if (nmren !== 4 || lat !== 5) begin miscompares++; $display("FAIL wh_timing got mren=%0d lat=%0d exp 4/5", nmren, lat); end
    vectors++; if (mdata_seen !== rd || mresp_seen !== 2'b10) begin miscompares++; $display("FAIL wh_result got %h/%b exp %h/10", mdata_seen, mresp_seen, rd); end
    vectors++; if ({hold_stable, ar_blocked, mready_after, arready_after} !== 4'b1101) begin miscompares++; $display("FAIL wh_hold_release got %b exp 1101", {hold_stable, ar_blocked, mready_after, arready_after}); end
    rd = $urandom;
    run_read(32'h48, 0, rd, 2'b00, 0, 1'b0);
    vectors++; if (arready_pre !== 1'b1 || lat !== 2 || mdata_seen !== rd || maddr_seen !== 32'd18) begin miscompares++; $display("FAIL b2b_second got ar=%b lat=%0d data=%h maddr=%0d exp 1/2/%h/18", arready_pre, lat, mdata_seen, maddr_seen, rd); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h20;
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    vectors++; if (bus.MREN !== 1'b1) begin miscompares++; $display("FAIL rm_mren_before got %b exp 1", bus.MREN); end
    #2 resetn = 1'b0; #1;
    vectors++; if ({bus.MREN, bus.ARREADY, bus.MREADY} !== 3'b000 || bus.MADDR !== '0) begin miscompares++; $display("FAIL rm_async got flags=%b maddr=%h exp 000/0", {bus.MREN, bus.ARREADY, bus.MREADY}, bus.MADDR); end
    @(posedge clk); @(negedge clk); resetn = 1'b1; #1;
    vectors++; if (bus.ARREADY !== 1'b0) begin miscompares++; $display("FAIL rm_arready_pre got %b exp 0", bus.ARREADY); end
    @(posedge clk); #1;
    vectors++; if ({bus.ARREADY, bus.MREN, bus.MREADY} !== 3'b100) begin miscompares++; $display("FAIL rm_idle got %b exp 100", {bus.ARREADY, bus.MREN, bus.MREADY}); end
    rd = $urandom;
    run_read(32'h30, 1, rd, 2'b00, 1, 1'b0);
    vectors++; if (nmren !== 2 || lat !== 3 || maddr_seen !== 32'd12 || mdata_seen !== rd) begin miscompares++; $display("FAIL rm_next_read got mren=%0d lat=%0d maddr=%0d data=%h exp 2/3/12/%h", nmren, lat, maddr_seen, mdata_seen, rd); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    logic [1:0] rs;
    int waits;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = 32'($urandom_range(0, MW - 1)) << 2;
        3:       a = (32'($urandom_range(0, MW - 1)) << 2) | 32'($urandom_range(1, 3));
        4:       a = $urandom & ~32'h3;
        default: a = 32'($urandom_range(MW - 1, MW)) << 2;
      endcase
      waits = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, TO + 1);
      rd = $urandom; rs = 2'($urandom);
      model(a, waits, rd, rs);
      run_read(a, waits, rd, rs, $urandom_range(0, 3), 1'($urandom));
      vectors++; if (nmren !== emren || lat !== elat) begin miscompares++; $display("FAIL rnd_timing a=%h got mren=%0d lat=%0d exp %0d/%0d", a, nmren, lat, emren, elat); end
      vectors++; if (mdata_seen !== edata || mresp_seen !== eresp) begin miscompares++; $display("FAIL rnd_result a=%h got %h/%b exp %h/%b", a, mdata_seen, mresp_seen, edata, eresp); end
      if (emren > 0) begin
        vectors++; if (maddr_seen !== (a >> 2) || maddr_stable !== 1'b1) begin miscompares++; $display("FAIL rnd_maddr got %h stable=%b exp %h/1", maddr_seen, maddr_stable, a >> 2); end
      end
      vectors++; if ({arready_pre, hold_stable, ar_blocked, mready_after, arready_after} !== 5'b11101) begin miscompares++; $display("FAIL rnd_handshake a=%h got %b exp 11101", a, {arready_pre, hold_stable, ar_blocked, mready_after, arready_after}); end
    end
  endtask

  initial begin
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = '0;
    bus.MEM_ACK = 1'b0; bus.MEM_RDATA = '0; bus.MEM_RESP = '0;
    bus.RVALID = 1'b0; bus.RREADY = 1'b0;
    test_reset();
    test_zero_wait();
    test_misaligned();
    test_range();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "bench did not finish");
  end
endmodule
